// File: rtl/rangefinder_capture_pkg.sv
// Shared definitions for the rangefinder sample-capture block.
//   cap_state_t : capture sequencer states
//   CSR_*       : CSR indices within the CSR half of the Avalon window
//   CTRL_*      : CTRL register bit positions (arm, abort, irq enable)
//   STAT_*      : STAT register bit positions (busy, done, trig_lost)
package rangefinder_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } cap_state_t;

    localparam logic [1:0] CSR_CTRL = 2'd0;
    localparam logic [1:0] CSR_STAT = 2'd1;
    localparam logic [1:0] CSR_PRE  = 2'd2;
    localparam logic [1:0] CSR_TPTR = 2'd3;

    localparam int unsigned CTRL_ARM   = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_IE    = 2;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_DONE      = 1;
    localparam int unsigned STAT_TRIG_LOST = 2;

endpackage

// File: rtl/rangefinder_sample_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : read data, valid the cycle after re (old data on same-address write)
module rangefinder_sample_dpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rangefinder_sample_capture.sv
// Triggered sample-capture buffer with an Avalon-MM slave.
//   clk, reset           : system clock, synchronous active-high reset
//   smp_valid, smp_data  : ADC sample stream
//   trig                 : trigger pulse
//   address              : MSB=1 sample window (trigger-aligned index), MSB=0 CSR in [1:0]
//   chipselect/read/write/writedata : Avalon slave inputs
//   readdata             : read data, latency 1, zero when no read was issued
//   irq                  : high while done && ie
module rangefinder_sample_capture
    import rangefinder_capture_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CSR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              trig,
    input  logic [ADDR_W:0]   address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [CSR_W-1:0]  writedata,
    output logic [CSR_W-1:0]  readdata,
    output logic              irq
);

    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [CSR_W-1:0] PRE_MAX = CSR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  ONE     = (ADDR_W+1)'(1);

    cap_state_t state, state_n;

    logic [ADDR_W-1:0] wr_ptr, fill_cnt, tptr, pre;
    logic [ADDR_W:0]   post_cnt, post_target;
    logic              ie, done, trig_lost;
    logic              ram_we, trig_take, trig_miss;
    logic              csr_wr, ctrl_wr, stat_wr, pre_wr, arm, abort, busy;
    logic              fill_last, post_last;
    logic              rd_valid, rd_sample;
    logic [CSR_W-1:0]  csr_rd, csr_q;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_q;

    assign csr_wr  = chipselect & write & ~address[ADDR_W];
    assign ctrl_wr = csr_wr & (address[1:0] == CSR_CTRL);
    assign stat_wr = csr_wr & (address[1:0] == CSR_STAT);
    assign pre_wr  = csr_wr & (address[1:0] == CSR_PRE);
    assign abort   = ctrl_wr & writedata[CTRL_ABORT];
    assign arm     = ctrl_wr & writedata[CTRL_ARM] & ~writedata[CTRL_ABORT];
    assign busy    = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);

    // Samples to store from the trigger sample onward (1..DEPTH).
    assign post_target = DEPTH_V - {1'b0, pre};
    assign fill_last   = ({1'b0, fill_cnt} + ONE) == {1'b0, pre};
    assign post_last   = (post_cnt + ONE) == post_target;

    always_comb begin
        state_n   = state;
        ram_we    = 1'b0;
        trig_take = 1'b0;
        trig_miss = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_FILL: begin
                ram_we    = smp_valid;
                trig_miss = trig;
                if (smp_valid && fill_last) state_n = ST_ARMED;
            end
            ST_ARMED: begin
                ram_we = smp_valid;
                if (trig) begin
                    trig_take = 1'b1;
                    state_n   = (smp_valid && post_target == ONE) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                ram_we    = smp_valid;
                trig_miss = trig;
                if (smp_valid && post_last) state_n = ST_DONE;
            end
            ST_DONE: ;
            default: state_n = ST_IDLE;
        endcase
        if (arm) begin
            state_n   = (pre == '0) ? ST_ARMED : ST_FILL;
            ram_we    = 1'b0;
            trig_take = 1'b0;
            trig_miss = 1'b0;
        end
        if (abort) begin
            state_n   = ST_IDLE;
            ram_we    = 1'b0;
            trig_take = 1'b0;
            trig_miss = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            tptr      <= '0;
            pre       <= '0;
            ie        <= 1'b0;
            done      <= 1'b0;
            trig_lost <= 1'b0;
            rd_valid  <= 1'b0;
            rd_sample <= 1'b0;
            csr_q     <= '0;
        end else begin
            state <= state_n;
            if (ram_we) wr_ptr <= wr_ptr + 1'b1;
            if (state == ST_FILL && ram_we) fill_cnt <= fill_cnt + 1'b1;
            if (trig_take) begin
                tptr     <= wr_ptr;
                post_cnt <= smp_valid ? ONE : '0;
            end else if (state == ST_POST && ram_we) begin
                post_cnt <= post_cnt + ONE;
            end
            if (trig_miss) trig_lost <= 1'b1;
            if (stat_wr && writedata[STAT_DONE]) done <= 1'b0;
            // Completion wins over a same-cycle W1C.
            if (state_n == ST_DONE && state != ST_DONE) done <= 1'b1;
            if (ctrl_wr) ie <= writedata[CTRL_IE];
            if (pre_wr && !busy) begin
                pre <= (writedata > PRE_MAX) ? ADDR_W'(PRE_MAX) : writedata[ADDR_W-1:0];
            end
            if (arm) begin
                wr_ptr    <= '0;
                fill_cnt  <= '0;
                done      <= 1'b0;
                trig_lost <= 1'b0;
            end
            if (abort) done <= 1'b0;
            rd_valid  <= chipselect & read;
            rd_sample <= address[ADDR_W];
            csr_q     <= csr_rd;
        end
    end

    always_comb begin
        csr_rd = '0;
        case (address[1:0])
            CSR_CTRL: csr_rd[0] = ie;
            CSR_STAT: begin
                csr_rd[STAT_BUSY]      = busy;
                csr_rd[STAT_DONE]      = done;
                csr_rd[STAT_TRIG_LOST] = trig_lost;
            end
            CSR_PRE:  csr_rd[ADDR_W-1:0] = pre;
            default:  csr_rd[ADDR_W-1:0] = tptr;
        endcase
    end

    // Window index 0 maps to the oldest stored sample, PRE entries before the trigger.
    assign ram_re    = chipselect & read & address[ADDR_W];
    assign ram_raddr = tptr - pre + address[ADDR_W-1:0];

    rangefinder_sample_dpram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (smp_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Both the RAM output and csr_q are registers; the final mux just picks
    // whichever one the previous cycle's access targeted.
    always_comb begin
        readdata = '0;
        if (rd_valid) begin
            readdata = rd_sample ? CSR_W'(ram_q) : csr_q;
        end
    end

    assign irq = done & ie;

endmodule

// File: tb/tb_rangefinder_sample_capture.sv
module tb_rangefinder_sample_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        smp_valid, trig, chipselect, read, write, irq;
    logic [7:0]  smp_data;
    logic [8:0]  address;
    logic [31:0] writedata, readdata;

    logic        s_smp_valid, s_trig, s_chipselect, s_read, s_write, s_irq;
    logic [11:0] s_smp_data;
    logic [4:0]  s_address;
    logic [31:0] s_writedata, s_readdata;

    rangefinder_sample_capture #(.DATA_W(8), .ADDR_W(8), .CSR_W(32)) u_dut (
        .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_data(smp_data), .trig(trig),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    rangefinder_sample_capture #(.DATA_W(12), .ADDR_W(4), .CSR_W(32)) u_small (
        .clk(clk), .reset(reset), .smp_valid(s_smp_valid), .smp_data(s_smp_data), .trig(s_trig),
        .address(s_address), .chipselect(s_chipselect), .read(s_read), .write(s_write),
        .writedata(s_writedata), .readdata(s_readdata), .irq(s_irq)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: the capture is the list of valid samples since arm;
    // the trigger sample is the first valid sample once PRE samples exist.
    int m_stream[$];
    int m_ram[256];
    int m_cnt, m_tidx, m_pre, m_depth;
    bit m_run, m_done, m_dflag, m_lost;
    int m_pre_reg[2];
    bit m_ie[2];
    int m_tptr[2];

    function automatic logic [31:0] exp_stat();
        return {29'd0, m_lost, m_dflag, (m_run && !m_done)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        smp_valid = 0; smp_data = '0; trig = 0; address = '0;
        chipselect = 0; read = 0; write = 0; writedata = '0;
        s_smp_valid = 0; s_smp_data = '0; s_trig = 0; s_address = '0;
        s_chipselect = 0; s_read = 0; s_write = 0; s_writedata = '0;
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_dflag = 0; m_lost = 0;
        m_cnt = 0; m_tidx = -1; m_pre = 0; m_depth = 256;
        m_stream.delete();
        for (int s = 0; s < 2; s++) begin
            m_pre_reg[s] = 0; m_ie[s] = 0; m_tptr[s] = 0;
        end
    endtask

    task automatic csr_write(input bit sel, input int idx, input int d);
        int depth;
        depth = sel ? 16 : 256;
        if (sel) begin
            s_address = 5'(idx); s_chipselect = 1; s_write = 1; s_writedata = d;
        end else begin
            address = 9'(idx); chipselect = 1; write = 1; writedata = d;
        end
        tick();
        chipselect = 0; write = 0; s_chipselect = 0; s_write = 0;
        case (idx)
            0: begin
                m_ie[sel] = d[2];
                if (d[1]) begin
                    m_run = 0; m_dflag = 0;
                end else if (d[0]) begin
                    m_run = 1; m_done = 0; m_dflag = 0; m_lost = 0;
                    m_cnt = 0; m_tidx = -1; m_stream.delete();
                    m_pre = m_pre_reg[sel]; m_depth = depth;
                end
            end
            1: if (d[1]) m_dflag = 0;
            2: if (!(m_run && !m_done)) m_pre_reg[sel] = (d > depth - 1) ? depth - 1 : d;
            default: ;
        endcase
    endtask

    task automatic csr_read(input bit sel, input int addr, output logic [31:0] v);
        if (sel) begin
            s_address = 5'(addr); s_chipselect = 1; s_read = 1;
        end else begin
            address = 9'(addr); chipselect = 1; read = 1;
        end
        tick();
        v = sel ? s_readdata : readdata;
        chipselect = 0; read = 0; s_chipselect = 0; s_read = 0;
    endtask

    task automatic feed(input bit sel, input bit v, input int d, input bit t);
        if (sel) begin
            s_smp_valid = v; s_smp_data = 12'(d); s_trig = t;
        end else begin
            smp_valid = v; smp_data = 8'(d); trig = t;
        end
        tick();
        smp_valid = 0; trig = 0; s_smp_valid = 0; s_trig = 0;
        if (m_run && !m_done) begin
            if (t) begin
                if (m_tidx < 0 && m_cnt >= m_pre) begin
                    m_tidx = m_cnt;
                    m_tptr[sel] = m_cnt % m_depth;
                end else begin
                    m_lost = 1;
                end
            end
            if (v) begin
                m_stream.push_back(d);
                if (!sel) m_ram[m_cnt % 256] = d;
                m_cnt++;
            end
            if (m_tidx >= 0 && m_cnt == m_tidx + m_depth - m_pre) begin
                m_done = 1; m_dflag = 1;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1;
        repeat (3) tick();
        reset = 0;
        model_reset();
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++;
        if (s_irq !== 1'b0) begin n_mis++; $display("FAIL reset_s_irq: got %b want 0", s_irq); end
        n_cmp++;
        if (readdata !== 32'd0) begin n_mis++; $display("FAIL reset_readdata: got %h want 0", readdata); end
        for (int i = 0; i < 4; i++) begin
            csr_read(0, i, v);
            n_cmp++;
            if (v !== 32'd0) begin n_mis++; $display("FAIL reset_csr%0d: got %h want 0", i, v); end
            csr_read(1, i, v);
            n_cmp++;
            if (v !== 32'd0) begin n_mis++; $display("FAIL reset_s_csr%0d: got %h want 0", i, v); end
        end
    endtask

    task automatic test_pre_clamp();
        logic [31:0] v;
        csr_write(0, 2, 1000);
        csr_read(0, 2, v);
        n_cmp++;
        if (v !== 32'd255) begin n_mis++; $display("FAIL pre_clamp: got %0d want 255", v); end
        csr_write(0, 2, 64);
        csr_read(0, 2, v);
        n_cmp++;
        if (v !== 32'(m_pre_reg[0])) begin n_mis++; $display("FAIL pre_write: got %0d want %0d", v, m_pre_reg[0]); end
    endtask

    task automatic test_ramp();
        logic [31:0] v;
        int sidx[3] = '{0, 64, 255};
        int sval[3] = '{36, 100, 35};
        csr_write(0, 2, 64);
        csr_write(0, 0, 5);
        for (int k = 0; k < 400 && !m_done; k++) feed(0, 1, k & 255, k == 100);
        for (int k = 0; k < 5; k++) feed(0, 1, 8'hAA, 0);
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat() || v !== 32'd2) begin n_mis++; $display("FAIL ramp_stat: got %h want %h", v, exp_stat()); end
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL ramp_irq: got %b want 1", irq); end
        csr_read(0, 3, v);
        n_cmp++;
        if (v !== 32'd100) begin n_mis++; $display("FAIL ramp_tptr: got %0d want 100", v); end
        for (int j = 0; j < 3; j++) begin
            csr_read(0, 256 + sidx[j], v);
            n_cmp++;
            if (v !== 32'(sval[j])) begin n_mis++; $display("FAIL ramp_sample%0d: got %0d want %0d", sidx[j], v, sval[j]); end
        end
        for (int i = 0; i < 256; i++) begin
            csr_read(0, 256 + i, v);
            n_cmp++;
            if (v !== 32'(m_stream[m_tidx - m_pre + i])) begin
                n_mis++; $display("FAIL ramp_window[%0d]: got %0d want %0d", i, v, m_stream[m_tidx - m_pre + i]);
            end
        end
    endtask

    task automatic test_pre0();
        logic [31:0] v;
        int d0;
        d0 = $urandom_range(0, 255);
        csr_write(0, 2, 0);
        csr_write(0, 0, 1);
        feed(0, 1, d0, 1);
        for (int k = 0; k < 2000 && !m_done; k++)
            feed(0, $urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 29) == 0);
        csr_read(0, 256, v);
        n_cmp++;
        if (v !== 32'(d0)) begin n_mis++; $display("FAIL pre0_first: got %0d want %0d", v, d0); end
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat()) begin n_mis++; $display("FAIL pre0_stat: got %h want %h", v, exp_stat()); end
        csr_read(0, 3, v);
        n_cmp++;
        if (v !== 32'd0) begin n_mis++; $display("FAIL pre0_tptr: got %0d want 0", v); end
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL pre0_irq: got %b want 0", irq); end
        for (int i = 0; i < 256; i++) begin
            csr_read(0, 256 + i, v);
            n_cmp++;
            if (v !== 32'(m_stream[m_tidx - m_pre + i])) begin
                n_mis++; $display("FAIL pre0_window[%0d]: got %0d want %0d", i, v, m_stream[m_tidx - m_pre + i]);
            end
        end
    endtask

    task automatic test_trig_lost();
        logic [31:0] v;
        int extra;
        csr_write(0, 2, 200);
        csr_write(0, 0, 5);
        for (int k = 0; k < 10; k++) feed(0, 1, $urandom_range(0, 255), 0);
        feed(0, $urandom_range(0, 1), $urandom_range(0, 255), 1);
        csr_write(0, 2, 5);
        csr_read(0, 2, v);
        n_cmp++;
        if (v !== 32'd200) begin n_mis++; $display("FAIL busy_pre_write: got %0d want 200", v); end
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat() || v !== 32'd5) begin n_mis++; $display("FAIL lost_stat_fill: got %h want %h", v, exp_stat()); end
        extra = $urandom_range(0, 30);
        for (int k = 0; k < 3000 && m_cnt < 200 + extra; k++)
            feed(0, $urandom_range(0, 2) != 0, $urandom_range(0, 255), 0);
        feed(0, $urandom_range(0, 1), $urandom_range(0, 255), 1);
        for (int k = 0; k < 3000 && !m_done; k++)
            feed(0, $urandom_range(0, 2) != 0, $urandom_range(0, 255), 0);
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat() || v !== 32'd6) begin n_mis++; $display("FAIL lost_stat_done: got %h want %h", v, exp_stat()); end
        csr_read(0, 3, v);
        n_cmp++;
        if (v !== 32'(m_tptr[0])) begin n_mis++; $display("FAIL lost_tptr: got %0d want %0d", v, m_tptr[0]); end
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL lost_irq: got %b want 1", irq); end
        for (int i = 0; i < 256; i++) begin
            csr_read(0, 256 + i, v);
            n_cmp++;
            if (v !== 32'(m_stream[m_tidx - m_pre + i])) begin
                n_mis++; $display("FAIL lost_window[%0d]: got %0d want %0d", i, v, m_stream[m_tidx - m_pre + i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        int e;
        csr_write(0, 2, 32);
        csr_write(0, 0, 5);
        for (int k = 0; k < 100; k++) feed(0, 1, $urandom_range(0, 255), 0);
        feed(0, 1, $urandom_range(0, 255), 1);
        for (int k = 0; k < 50; k++) feed(0, 1, $urandom_range(0, 255), 0);
        csr_write(0, 0, 6);
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat() || v[1:0] !== 2'b00) begin n_mis++; $display("FAIL abort_stat: got %h want %h", v, exp_stat()); end
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL abort_irq: got %b want 0", irq); end
        for (int k = 0; k < 30; k++) feed(0, 1, $urandom_range(0, 255), k == 3);
        for (int i = 0; i < 256; i++) begin
            csr_read(0, 256 + i, v);
            e = m_ram[(m_tptr[0] - m_pre_reg[0] + i) & 255];
            n_cmp++;
            if (v !== 32'(e)) begin n_mis++; $display("FAIL abort_ram[%0d]: got %0d want %0d", i, v, e); end
        end
        csr_write(0, 0, 3);
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat()) begin n_mis++; $display("FAIL arm_abort_stat: got %h want %h", v, exp_stat()); end
        csr_write(0, 2, 250);
        csr_write(0, 0, 5);
        for (int k = 0; k < 600 && !m_done; k++)
            feed(0, 1, $urandom_range(0, 255), m_cnt >= 250 && m_tidx < 0);
        n_cmp++;
        if (irq !== (m_dflag & m_ie[0]) || irq !== 1'b1) begin n_mis++; $display("FAIL w1c_irq_before: got %b want 1", irq); end
        csr_write(0, 1, 2);
        n_cmp++;
        if (irq !== (m_dflag & m_ie[0])) begin n_mis++; $display("FAIL w1c_irq_after: got %b want %b", irq, m_dflag & m_ie[0]); end
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat()) begin n_mis++; $display("FAIL w1c_stat: got %h want %h", v, exp_stat()); end
    endtask

    task automatic test_reset_post();
        logic [31:0] v;
        csr_write(0, 2, 16);
        csr_write(0, 0, 5);
        for (int k = 0; k < 40; k++) feed(0, 1, $urandom_range(0, 255), 0);
        feed(0, 1, $urandom_range(0, 255), 1);
        for (int k = 0; k < 10; k++) feed(0, 1, $urandom_range(0, 255), 0);
        csr_read(0, 1, v);
        n_cmp++;
        if (v !== exp_stat() || v !== 32'd1) begin n_mis++; $display("FAIL post_busy: got %h want %h", v, exp_stat()); end
        address = 9'd1; chipselect = 1; read = 1; reset = 1;
        tick();
        chipselect = 0; read = 0;
        n_cmp++;
        if (readdata !== 32'd0) begin n_mis++; $display("FAIL rst_post_readdata: got %h want 0", readdata); end
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL rst_post_irq: got %b want 0", irq); end
        reset = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            csr_read(0, i, v);
            n_cmp++;
            if (v !== 32'd0) begin n_mis++; $display("FAIL rst_post_csr%0d: got %h want 0", i, v); end
        end
    endtask

    task automatic test_small();
        logic [31:0] v;
        csr_write(1, 2, 20);
        csr_read(1, 2, v);
        n_cmp++;
        if (v !== 32'd15) begin n_mis++; $display("FAIL small_pre_clamp: got %0d want 15", v); end
        csr_write(1, 2, 5);
        csr_write(1, 0, 5);
        for (int k = 0; k < 500 && !m_done; k++)
            feed(1, $urandom_range(0, 3) != 0, $urandom_range(0, 4095),
                 (m_cnt >= 8 && m_tidx < 0) || $urandom_range(0, 15) == 0);
        csr_read(1, 1, v);
        n_cmp++;
        if (v !== exp_stat()) begin n_mis++; $display("FAIL small_stat: got %h want %h", v, exp_stat()); end
        csr_read(1, 3, v);
        n_cmp++;
        if (v !== 32'(m_tptr[1])) begin n_mis++; $display("FAIL small_tptr: got %0d want %0d", v, m_tptr[1]); end
        n_cmp++;
        if (s_irq !== 1'b1) begin n_mis++; $display("FAIL small_irq: got %b want 1", s_irq); end
        for (int i = 0; i < 16; i++) begin
            csr_read(1, 16 + i, v);
            n_cmp++;
            if (v !== 32'(m_stream[m_tidx - m_pre + i])) begin
                n_mis++; $display("FAIL small_window[%0d]: got %h want %h", i, v, m_stream[m_tidx - m_pre + i]);
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        idle_inputs();
        for (int i = 0; i < 256; i++) m_ram[i] = 0;
        model_reset();
        test_reset();
        test_pre_clamp();
        test_ramp();
        test_pre0();
        test_trig_lost();
        test_abort();
        test_reset_post();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
